mem_stage_lsu: RTL and testbench

//  Parametrised MEM stage with a load/store unit. It replaces the pass-through MEM stage.
//  - Forwards EX results and HI/LO writes to WB.
//  - Executes byte, half and word loads/stores on a valid/ready data-RAM port.
//  - Stalls the pipeline while a bus access is outstanding.
//  - Flags misaligned accesses.
//  - Holds the MEM/WB register, so every WB-side output is registered.

---
 rtl/mem_stage_lsu_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 75 +++++++
 rtl/mem_stage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage load/store unit: memory op codes,
// FSM state encoding and reset polarity.
package mem_stage_lsu_pkg;

  localparam int MEM_OP_BUS = 4;
  typedef logic [MEM_OP_BUS-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NONE = 4'd0;
  localparam mem_op_t MEM_OP_LB   = 4'd1;
  localparam mem_op_t MEM_OP_LBU  = 4'd2;
  localparam mem_op_t MEM_OP_LH   = 4'd3;
  localparam mem_op_t MEM_OP_LHU  = 4'd4;
  localparam mem_op_t MEM_OP_LW   = 4'd5;
  localparam mem_op_t MEM_OP_SB   = 4'd6;
  localparam mem_op_t MEM_OP_SH   = 4'd7;
  localparam mem_op_t MEM_OP_SW   = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  localparam logic RST_ENABLE = 1'b0;

  function automatic logic is_mem_op(input mem_op_t op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_store_op(input mem_op_t op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, load lane
// select with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [MEM_OP_BUS-1:0] i_mem_op,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_store_data,
  input  logic [DATA_W-1:0]     i_rdata,
  output logic [DATA_W/8-1:0]   o_we,
  output logic [ADDR_W-1:0]     o_word_addr,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W-1:0]     o_load_data,
  output logic                  o_misaligned
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam logic [NB-1:0] ONE_LANE  = NB'(1);
  localparam logic [NB-1:0] TWO_LANES = NB'(3);

  logic [LANE_W-1:0] w_lane;
  logic [DATA_W-1:0] w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_lane      = i_addr[LANE_W-1:0];
  assign w_shifted   = i_rdata >> {w_lane, 3'b000};
  assign w_byte      = w_shifted[7:0];
  assign w_half      = w_shifted[15:0];
  assign o_word_addr = {i_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  // Per-op lane steering and alignment check
  always_comb begin
    o_misaligned = 1'b0;
    o_we         = '0;
    o_wdata      = '0;
    o_load_data  = '0;
    case (i_mem_op)
      MEM_OP_LB:  o_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      MEM_OP_LBU: o_load_data = {{(DATA_W-8){1'b0}}, w_byte};
      MEM_OP_LH: begin
        o_misaligned = i_addr[0];
        o_load_data  = {{(DATA_W-16){w_half[15]}}, w_half};
      end
      MEM_OP_LHU: begin
        o_misaligned = i_addr[0];
        o_load_data  = {{(DATA_W-16){1'b0}}, w_half};
      end
      MEM_OP_LW: begin
        o_misaligned = |w_lane;
        o_load_data  = i_rdata;
      end
      MEM_OP_SB: begin
        o_we    = ONE_LANE << w_lane;
        o_wdata = {NB{i_store_data[7:0]}};
      end
      MEM_OP_SH: begin
        o_misaligned = i_addr[0];
        o_we         = TWO_LANES << w_lane;
        o_wdata      = {(NB/2){i_store_data[15:0]}};
      end
      MEM_OP_SW: begin
        o_misaligned = |w_lane;
        o_we         = '1;
        o_wdata      = i_store_data;
      end
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load/store unit: drives a valid/ready data-RAM port,
// stalls upstream while an access is outstanding and holds the MEM/WB register.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [MEM_OP_BUS-1:0] mem_op_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic                  write_reg_en_in,
  input  logic [RADDR_W-1:0]    write_reg_addr_in,
  input  logic                  write_hilo_en_in,
  input  logic [DATA_W-1:0]     write_hi_data_in,
  input  logic [DATA_W-1:0]     write_lo_data_in,
  output logic                  stall_req,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_ready,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     result_out,
  output logic                  write_reg_en_out,
  output logic [RADDR_W-1:0]    write_reg_addr_out,
  output logic                  write_hilo_en_out,
  output logic [DATA_W-1:0]     write_hi_data_out,
  output logic [DATA_W-1:0]     write_lo_data_out,
  output logic                  addr_error_out
);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;

  logic                w_run;
  logic                w_is_mem;
  logic                w_is_store;
  logic                w_misaligned;
  logic                w_addr_err;
  logic                w_req;
  logic                w_complete;
  logic [DATA_W/8-1:0] w_we;
  logic [ADDR_W-1:0]   w_word_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_load_data;

  logic                w_valid_nxt;
  logic [DATA_W-1:0]   w_result_nxt;
  logic                w_reg_en_nxt;
  logic [RADDR_W-1:0]  w_reg_addr_nxt;
  logic                w_hilo_en_nxt;
  logic [DATA_W-1:0]   w_hi_nxt;
  logic [DATA_W-1:0]   w_lo_nxt;
  logic                w_addr_err_nxt;

  mem_lane_align #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_align (
    .i_mem_op     (mem_op_in),
    .i_addr       (result_in[ADDR_W-1:0]),
    .i_store_data (store_data_in),
    .i_rdata      (ram_rdata),
    .o_we         (w_we),
    .o_word_addr  (w_word_addr),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  // Bus outputs are gated by reset so an access in flight is dropped at once
  assign w_run      = (rst != RST_ENABLE);
  assign w_is_mem   = valid_in & is_mem_op(mem_op_in);
  assign w_is_store = w_is_mem & is_store_op(mem_op_in);
  assign w_addr_err = w_is_mem & w_misaligned;
  assign w_req      = w_is_mem & ~w_misaligned;

  assign ram_en     = w_run & (w_req | (r_state == ST_WAIT));
  assign stall_req  = ram_en & ~ram_ready;
  assign ram_we     = ram_en ? w_we        : '0;
  assign ram_addr   = ram_en ? w_word_addr : '0;
  assign ram_wdata  = ram_en ? w_wdata     : '0;
  assign w_complete = w_run & valid_in & ~stall_req;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !ram_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ram_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next MEM/WB contents; a stall or empty slot becomes a bubble
  always_comb begin
    w_valid_nxt    = 1'b0;
    w_result_nxt   = '0;
    w_reg_en_nxt   = 1'b0;
    w_reg_addr_nxt = '0;
    w_hilo_en_nxt  = 1'b0;
    w_hi_nxt       = '0;
    w_lo_nxt       = '0;
    w_addr_err_nxt = 1'b0;
    if (w_complete) begin
      w_valid_nxt    = 1'b1;
      w_result_nxt   = (w_req && !w_is_store) ? w_load_data : result_in;
      w_reg_en_nxt   = write_reg_en_in & ~w_addr_err & ~w_is_store;
      w_reg_addr_nxt = write_reg_addr_in;
      w_hilo_en_nxt  = write_hilo_en_in;
      w_hi_nxt       = write_hi_data_in;
      w_lo_nxt       = write_lo_data_in;
      w_addr_err_nxt = w_addr_err;
    end else begin
      w_valid_nxt    = 1'b0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_out          <= 1'b0;
      result_out         <= '0;
      write_reg_en_out   <= 1'b0;
      write_reg_addr_out <= '0;
      write_hilo_en_out  <= 1'b0;
      write_hi_data_out  <= '0;
      write_lo_data_out  <= '0;
      addr_error_out     <= 1'b0;
    end else begin
      valid_out          <= w_valid_nxt;
      result_out         <= w_result_nxt;
      write_reg_en_out   <= w_reg_en_nxt;
      write_reg_addr_out <= w_reg_addr_nxt;
      write_hilo_en_out  <= w_hilo_en_nxt;
      write_hi_data_out  <= w_hi_nxt;
      write_lo_data_out  <= w_lo_nxt;
      addr_error_out     <= w_addr_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed literal cases plus random
// traffic compared every cycle against a behavioural model.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [3:0]  mem_op_in;
  logic [31:0] result_in, store_data_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        write_hilo_en_in;
  logic [31:0] write_hi_data_in, write_lo_data_in;
  logic        stall_req, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ready;
  logic        valid_out;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        write_hilo_en_out;
  logic [31:0] write_hi_data_out, write_lo_data_out;
  logic        addr_error_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op_in(mem_op_in),
    .result_in(result_in), .store_data_in(store_data_in),
    .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
    .write_hilo_en_in(write_hilo_en_in), .write_hi_data_in(write_hi_data_in),
    .write_lo_data_in(write_lo_data_in), .stall_req(stall_req), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready), .valid_out(valid_out),
    .result_out(result_out), .write_reg_en_out(write_reg_en_out),
    .write_reg_addr_out(write_reg_addr_out), .write_hilo_en_out(write_hilo_en_out),
    .write_hi_data_out(write_hi_data_out), .write_lo_data_out(write_lo_data_out),
    .addr_error_out(addr_error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_is_mem(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
    if (op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) return (a % 2) != 0;
    if (op == MEM_OP_LW || op == MEM_OP_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_we(input logic [3:0] op, input logic [31:0] a);
    if (op == MEM_OP_SB) return 4'(32'd1 << (a % 4));
    if (op == MEM_OP_SH) return 4'(32'd3 << (a % 4));
    if (op == MEM_OP_SW) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == MEM_OP_SB) return (sd & 32'hFF) * 32'h0101_0101;
    if (op == MEM_OP_SH) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] b = (rd >> sh) & 32'hFF;
    logic [31:0] h = (rd >> sh) & 32'hFFFF;
    case (op)
      MEM_OP_LB:  return (b >= 32'd128)   ? b - 32'd256   : b;
      MEM_OP_LBU: return b;
      MEM_OP_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      MEM_OP_LHU: return h;
      default:    return rd;
    endcase
  endfunction

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        wen;
    logic [4:0]  waddr;
    logic        hen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        aerr;
    logic        store;
  } wb_t;

  wb_t exp_wb = '0;

  // Per-cycle compare against the model; bus checked combinationally, WB one edge later
  always @(negedge clk) begin
    bit m_req;
    if (!rst) begin
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_result", result_out, 32'd0);
      chk("rst_wen", {31'd0, write_reg_en_out}, 32'd0);
      chk("rst_aerr", {31'd0, addr_error_out}, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      exp_wb = '0;
    end else begin
      chk("wb_valid", {31'd0, valid_out}, {31'd0, exp_wb.valid});
      chk("wb_wen", {31'd0, write_reg_en_out}, {31'd0, exp_wb.wen});
      chk("wb_hen", {31'd0, write_hilo_en_out}, {31'd0, exp_wb.hen});
      chk("wb_aerr", {31'd0, addr_error_out}, {31'd0, exp_wb.aerr});
      if (exp_wb.valid) begin
        chk("wb_waddr", {27'd0, write_reg_addr_out}, {27'd0, exp_wb.waddr});
        chk("wb_hi", write_hi_data_out, exp_wb.hi);
        chk("wb_lo", write_lo_data_out, exp_wb.lo);
        if (!exp_wb.store) chk("wb_result", result_out, exp_wb.result);
      end
      m_req = valid_in && m_is_mem(mem_op_in) && !m_misal(mem_op_in, result_in);
      chk("bus_en", {31'd0, ram_en}, {31'd0, m_req});
      chk("bus_stall", {31'd0, stall_req}, {31'd0, m_req && !ram_ready});
      if (m_req) begin
        chk("bus_addr", ram_addr, result_in & 32'hFFFF_FFFC);
        chk("bus_we", {28'd0, ram_we}, {28'd0, m_we(mem_op_in, result_in)});
        if (m_is_store(mem_op_in)) chk("bus_wdata", ram_wdata, m_wdata(mem_op_in, store_data_in));
      end
      exp_wb = '0;
      if (valid_in && !(m_req && !ram_ready)) begin
        exp_wb.valid = 1'b1;
        exp_wb.store = m_is_store(mem_op_in);
        exp_wb.aerr  = m_is_mem(mem_op_in) && m_misal(mem_op_in, result_in);
        exp_wb.wen   = write_reg_en_in && !exp_wb.aerr && !exp_wb.store;
        exp_wb.waddr = write_reg_addr_in;
        exp_wb.hen   = write_hilo_en_in;
        exp_wb.hi    = write_hi_data_in;
        exp_wb.lo    = write_lo_data_in;
        exp_wb.result = m_req ? m_load(mem_op_in, result_in, ram_rdata) : result_in;
      end
    end
  end

  task automatic set_in(input bit v, input logic [3:0] op, input logic [31:0] r,
                        input logic [31:0] sd, input bit wen, input logic [4:0] wa);
    valid_in          = v;
    mem_op_in         = op;
    result_in         = r;
    store_data_in     = sd;
    write_reg_en_in   = wen;
    write_reg_addr_in = wa;
    write_hilo_en_in  = 1'b0;
    write_hi_data_in  = 32'd0;
    write_lo_data_in  = 32'd0;
  endtask

  initial begin
    logic [31:0] cap_addr;
    bit hold;
    int waitc;
    rst = 1'b0;
    ram_ready = 1'b0;
    ram_rdata = 32'd0;
    set_in(1'b0, MEM_OP_NONE, 32'd0, 32'd0, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;

    // 1: ALU op passes in one cycle
    @(posedge clk); #1;
    set_in(1'b1, MEM_OP_NONE, 32'h1234_5678, 32'd0, 1'b1, 5'd5);
    ram_ready = 1'b1;
    @(negedge clk); chk("t1_ram_en", {31'd0, ram_en}, 32'd0);
    @(posedge clk); #1;
    chk("t1_result", result_out, 32'h1234_5678);
    chk("t1_wen", {31'd0, write_reg_en_out}, 32'd1);
    chk("t1_waddr", {27'd0, write_reg_addr_out}, 32'd5);

    // 2: LB sign-extended, ready same cycle
    set_in(1'b1, MEM_OP_LB, 32'h0000_0103, 32'd0, 1'b1, 5'd6);
    ram_rdata = 32'h80FF_0000;
    @(negedge clk);
    chk("t2_ram_addr", ram_addr, 32'h0000_0100);
    chk("t2_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("t2_result", result_out, 32'hFFFF_FF80);

    // 3: LHU with three wait cycles; bus must hold steady
    set_in(1'b1, MEM_OP_LHU, 32'h0000_0102, 32'd0, 1'b1, 5'd7);
    ram_ready = 1'b0;
    ram_rdata = 32'hDEAD_BEEF;
    cap_addr = 32'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall", {31'd0, stall_req}, 32'd1);
      chk("t3_ram_en", {31'd0, ram_en}, 32'd1);
      if (k == 0) cap_addr = ram_addr;
      else chk("t3_addr_stable", ram_addr, cap_addr);
      chk("t3_ram_addr", ram_addr, 32'h0000_0100);
      @(posedge clk); #1;
      chk("t3_bubble", {31'd0, valid_out}, 32'd0);
    end
    ram_ready = 1'b1;
    ram_rdata = 32'h8001_0000;
    @(negedge clk); chk("t3_stall_end", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("t3_result", result_out, 32'h0000_8001);
    chk("t3_valid", {31'd0, valid_out}, 32'd1);

    // 4: SB lane 1
    set_in(1'b1, MEM_OP_SB, 32'h0000_0101, 32'h0000_00AB, 1'b1, 5'd8);
    @(negedge clk);
    chk("t4_we", {28'd0, ram_we}, 32'h0000_0002);
    chk("t4_wdata", ram_wdata, 32'hABAB_ABAB);
    @(posedge clk); #1;
    chk("t4_wen", {31'd0, write_reg_en_out}, 32'd0);
    chk("t4_valid", {31'd0, valid_out}, 32'd1);

    // 5: misaligned LW
    set_in(1'b1, MEM_OP_LW, 32'h0000_0102, 32'd0, 1'b1, 5'd9);
    @(negedge clk);
    chk("t5_ram_en", {31'd0, ram_en}, 32'd0);
    chk("t5_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("t5_aerr", {31'd0, addr_error_out}, 32'd1);
    chk("t5_result", result_out, 32'h0000_0102);
    chk("t5_wen", {31'd0, write_reg_en_out}, 32'd0);

    // Random traffic checked by the per-cycle model
    hold = 1'b0;
    waitc = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 8));
        set_in($urandom_range(0, 9) != 0, op,
               {20'd0, 12'($urandom)}, $urandom, 1'($urandom), 5'($urandom));
        write_hilo_en_in = (op == MEM_OP_NONE) ? 1'($urandom) : 1'b0;
        write_hi_data_in = $urandom;
        write_lo_data_in = $urandom;
      end
      ram_ready = (waitc >= 3 || i == 799) ? 1'b1 : 1'($urandom);
      ram_rdata = $urandom;
      hold  = valid_in && m_is_mem(mem_op_in) && !m_misal(mem_op_in, result_in) && !ram_ready;
      waitc = hold ? waitc + 1 : 0;
      @(posedge clk); #1;
    end

    // 6: reset pulled during WAIT
    set_in(1'b1, MEM_OP_LW, 32'h0000_0200, 32'd0, 1'b1, 5'd3);
    ram_ready = 1'b0;
    @(posedge clk); #2;
    chk("t6_wait_en", {31'd0, ram_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_ram_en", {31'd0, ram_en}, 32'd0);
    chk("t6_stall", {31'd0, stall_req}, 32'd0);
    chk("t6_valid", {31'd0, valid_out}, 32'd0);
    chk("t6_result", result_out, 32'd0);
    set_in(1'b1, MEM_OP_NONE, 32'hCAFE_F00D, 32'd0, 1'b1, 5'd7);
    ram_ready = 1'b1;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_alu_result", result_out, 32'hCAFE_F00D);
    chk("t6_alu_valid", {31'd0, valid_out}, 32'd1);
    chk("t6_alu_waddr", {27'd0, write_reg_addr_out}, 32'd7);
    set_in(1'b0, MEM_OP_NONE, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
